// File: rtl/spdif_pkg.sv
// S/PDIF transmitter shared constants: preambles, slot map, block length,
// and the subframe slot-word builder.
package spdif_pkg;

    localparam logic [7:0] PRE_Z = 8'b00010111;
    localparam logic [7:0] PRE_X = 8'b01000111;
    localparam logic [7:0] PRE_Y = 8'b00100111;

    localparam int AUDIO_LO         = 4;
    localparam int VALIDITY         = 28;
    localparam int USER             = 29;
    localparam int CSTAT            = 30;
    localparam int PARITY           = 31;
    localparam int FRAMES_PER_BLOCK = 192;
    localparam int SUBFRAMES        = 2 * FRAMES_PER_BLOCK;

    typedef logic [31:0] subframe_t;

    // Slots 0..3 are unused here: the preamble is sent from its own register.
    function automatic subframe_t build_subframe(
        input logic [23:0] aud,
        input logic        vld,
        input logic        cst
    );
        subframe_t w;
        w                    = '0;
        w[27:AUDIO_LO]       = aud;
        w[VALIDITY]          = vld;
        w[USER]              = 1'b0;
        w[CSTAT]             = cst;
        w[PARITY]            = ^w[CSTAT:AUDIO_LO];
        return w;
    endfunction

endpackage

// File: rtl/spdif_bitclk_gen.sv
// Fractional half-bit enable: phase accumulator stepping by BIT_CLK and
// wrapping at the system clock rate.
module spdif_bitclk_gen #(
    parameter int unsigned BIT_CLK = 6144000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] clk_rate_i,
    output logic        en_o
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [32:0] acc_next;

    always_comb begin
        acc_next = {1'b0, acc_q} + 33'(BIT_CLK);
        en_o     = acc_next >= {1'b0, clk_rate_i};
        acc_d    = en_o ? 32'(acc_next - {1'b0, clk_rate_i})
                        : acc_next[31:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/spdif_tx_param.sv
// S/PDIF (IEC 60958) transmitter with one-pair input buffer and BMC line.
// Define SPDIF_TX_CHSTAT_EN to take channel-status bits 0..23 from cs_i.
module spdif_tx_param
    import spdif_pkg::*;
#(
    parameter int          SAMPLE_W = 24,
    parameter int unsigned BIT_CLK  = 6144000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         clk_rate_i,
    input  logic [SAMPLE_W-1:0] sample_l_i,
    input  logic [SAMPLE_W-1:0] sample_r_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    input  logic [23:0]         cs_i,
    output logic                spdif_o,
    output logic                block_start_o,
    output logic                underrun_o
);

    localparam int PAD = 24 - SAMPLE_W;

    function automatic logic [23:0] align(input logic [SAMPLE_W-1:0] s);
        return 24'(s) << PAD;
    endfunction

    logic en;

    spdif_bitclk_gen #(.BIT_CLK(BIT_CLK)) u_bitclk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clk_rate_i (clk_rate_i),
        .en_o       (en)
    );

    logic [5:0]          half_q, half_d;
    logic [8:0]          cnt_q, cnt_d;
    logic                pend_q, pend_d;
    subframe_t           sf_q, sf_d;
    logic [7:0]          pre_q, pre_d;
    logic                inv_q, inv_d;
    logic                spdif_q, spdif_d;
    logic                blk_q, blk_d;
    logic                und_q, und_d;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d;
    logic [SAMPLE_W-1:0] buf_r_q, buf_r_d;
    logic [23:0]         nxt_r_q, nxt_r_d;
    logic                nxt_v_q, nxt_v_d;
`ifdef SPDIF_TX_CHSTAT_EN
    logic [23:0]         cs_q, cs_d;
`else
    logic                unused_cs;
    assign unused_cs = ^cs_i;
`endif

    logic       load;
    logic       left;
    logic       take;
    logic       csb;
    logic [7:0] pre_sel;

    always_comb begin
        load    = en & (pend_q | (half_q == 6'd63));
        left    = ~cnt_q[0];
        take    = sample_valid_i & ~full_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sf_d    = sf_q;
        pre_d   = pre_q;
        inv_d   = inv_q;
        spdif_d = spdif_q;
        blk_d   = 1'b0;
        und_d   = 1'b0;
        full_d  = full_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        nxt_r_d = nxt_r_q;
        nxt_v_d = nxt_v_q;
        csb     = 1'b0;
        pre_sel = PRE_Y;
`ifdef SPDIF_TX_CHSTAT_EN
        cs_d    = cs_q;
        if (cnt_q == 9'd0) begin
            csb = cs_i[0];
        end else if (cnt_q[8:1] < 8'd24) begin
            csb = cs_q[cnt_q[5:1]];
        end
`else
        csb = (cnt_q[8:1] == 8'd2);
`endif
        if (take) begin
            full_d  = 1'b1;
            buf_l_d = sample_l_i;
            buf_r_d = sample_r_i;
        end
        if (load) begin
            pend_d = 1'b0;
            half_d = 6'd0;
            inv_d  = spdif_q;
            cnt_d  = (cnt_q == 9'(SUBFRAMES - 1)) ? 9'd0 : cnt_q + 9'd1;
            blk_d  = (cnt_q == 9'd0);
            if (cnt_q == 9'd0) begin
                pre_sel = PRE_Z;
            end else if (left) begin
                pre_sel = PRE_X;
            end
            pre_d = pre_sel;
`ifdef SPDIF_TX_CHSTAT_EN
            if (cnt_q == 9'd0) begin
                cs_d = cs_i;
            end
`endif
            if (left && full_q) begin
                sf_d    = build_subframe(align(buf_l_q), 1'b0, csb);
                nxt_r_d = align(buf_r_q);
                nxt_v_d = 1'b0;
                if (!take) begin
                    full_d = 1'b0;
                end
            end else if (left) begin
                sf_d    = build_subframe(24'd0, 1'b1, csb);
                nxt_r_d = 24'd0;
                nxt_v_d = 1'b1;
                und_d   = 1'b1;
            end else begin
                sf_d = build_subframe(nxt_r_q, nxt_v_q, csb);
            end
            spdif_d = pre_sel[0] ^ spdif_q;
        end else if (en) begin
            half_d = half_q + 6'd1;
            // BMC: edge at every slot start, extra mid-slot edge for a 1
            if (half_d < 6'd8) begin
                spdif_d = pre_q[half_d[2:0]] ^ inv_q;
            end else if (!half_d[0]) begin
                spdif_d = ~spdif_q;
            end else begin
                spdif_d = spdif_q ^ sf_q[half_d[5:1]];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            half_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b1;
            sf_q    <= '0;
            pre_q   <= '0;
            inv_q   <= 1'b0;
            spdif_q <= 1'b0;
            blk_q   <= 1'b0;
            und_q   <= 1'b0;
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            nxt_r_q <= '0;
            nxt_v_q <= 1'b0;
`ifdef SPDIF_TX_CHSTAT_EN
            cs_q    <= '0;
`endif
        end else begin
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sf_q    <= sf_d;
            pre_q   <= pre_d;
            inv_q   <= inv_d;
            spdif_q <= spdif_d;
            blk_q   <= blk_d;
            und_q   <= und_d;
            full_q  <= full_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            nxt_r_q <= nxt_r_d;
            nxt_v_q <= nxt_v_d;
`ifdef SPDIF_TX_CHSTAT_EN
            cs_q    <= cs_d;
`endif
        end
    end

    assign sample_ready_o = ~full_q;
    assign spdif_o        = spdif_q;
    assign block_start_o  = blk_q;
    assign underrun_o     = und_q;

endmodule

// File: doc/spdif_tx_param.md
SPDIF_TX_PARAM -- requirements
Module: spdif_tx_param

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24, meaning audio sample width in bits; the legal values are 16, 20 and 24.
REQ-002 SHALL have parameter BIT_CLK, default 6144000, meaning the half-bit rate in Hz (32 slots x 2 half-bits x 2 channels x Fs).
REQ-003 SHALL have port clk_i, input, width 1: the system clock.
REQ-004 SHALL have port rst_i, input, width 1: reset, asynchronous, active-high.
REQ-005 SHALL have port clk_rate_i, input, width 32: the clk_i frequency in Hz.
REQ-006 SHALL have port sample_l_i, input, width SAMPLE_W: the left sample, two's complement.
REQ-007 SHALL have port sample_r_i, input, width SAMPLE_W: the right sample.
REQ-008 SHALL have port sample_valid_i, input, width 1: the L/R pair is offered.
REQ-009 SHALL have port sample_ready_o, output, width 1: the block can accept a pair.
REQ-010 SHALL have port cs_i, input, width 24: channel-status bits 0..23 (see REQ-025).
REQ-011 SHALL have port spdif_o, output, width 1: the BMC-encoded line.
REQ-012 SHALL have port block_start_o, output, width 1: a one-cycle pulse when a Z-preamble subframe is loaded.
REQ-013 SHALL have port underrun_o, output, width 1: a one-cycle pulse when a left subframe is loaded with no pair buffered.

Function
REQ-014 Half-bit enable: each cycle, acc_next = acc + BIT_CLK. If acc_next >= clk_rate_i, then acc <= acc_next - clk_rate_i and en is 1 for that cycle. Otherwise acc <= acc_next and en is 0.
REQ-015 Subframe = 64 half-bit periods (slot = half-bit index / 2), advanced only on en. A load occurs on the en following half-bit 63.
REQ-016 Subframe counter 0..383, incremented at each load, wraps 383 -> 0. Even count = left, odd count = right. Frame index = count / 2.
REQ-017 Preamble selection: Z (8'b00010111) at count 0, X (8'b01000111) at other even counts, Y (8'b00100111) at odd counts. Preamble bits are sent LSB first, one per half-bit, during half-bits 0..7.
REQ-018 Line-level rule: the preamble is sent inverted if spdif_o = 1 at the load, and as listed otherwise.
REQ-019 Slot map:
- 4..27 = audio, LSB first, MSB at slot 27; for SAMPLE_W < 24, slots 4..(27-SAMPLE_W) are 0.
- 28 = validity.
- 29 = user bit = 0.
- 30 = channel-status bit.
- 31 = even parity over slots 4..30.
REQ-020 BMC: the line toggles at the start of every slot; for a slot value of 1 it also toggles at mid-slot.
REQ-021 Buffer: one-entry pair holding register. sample_ready_o = ~full (combinational). A transfer occurs on a cycle with sample_valid_i && sample_ready_o.
REQ-022 On a left load with the buffer full: consume the pair, L goes to the current subframe, R is latched for the next subframe, full <= 0. A transfer in the same cycle SHALL NOT be lost; full stays 1 holding the new pair.
REQ-023 On a left load with the buffer empty: transmit 0 for both L and R, with validity = 1 for both subframes, and pulse underrun_o.
REQ-024 block_start_o pulses on the load cycle of count 0.

Reset
REQ-026 While rst_i is high:
- acc, subframe counter and half-bit counter = 0; buffer empty.
- spdif_o = 0, block_start_o = 0, underrun_o = 0, sample_ready_o = 1.
- A load is pending, so the first subframe after release is Z.
REQ-027 A reset asserted mid-subframe SHALL abort that subframe immediately, with no partial-frame completion.

Configuration
REQ-025 With macro SPDIF_TX_CHSTAT_EN defined, the channel-status bit in both subframes of frame f (f < 24) SHALL be cs_i[f], sampled at the load of count 0 and held for the whole block; for frames 24..191 it is 0. Without the macro, cs_i is ignored; the bit is 1 only in frame 2 (copy permitted), else 0.

Structure
REQ-028 Package spdif_pkg SHALL hold the preamble constants, the slot indices (AUDIO_LO = 4, VALIDITY = 28, USER = 29, CSTAT = 30, PARITY = 31) and FRAMES_PER_BLOCK = 192.
REQ-029 The half-bit enable generator SHALL be the sub-module spdif_bitclk_gen, with ports clk_i, rst_i, clk_rate_i and en_o, and parameter BIT_CLK.

Verification
REQ-030 clk_rate_i = 24576000, BIT_CLK = 6144000 -> en every 4th cycle exactly; at clk_rate_i = 25000000 the long-run en rate matches within 1 per 10^6 cycles.
REQ-031 SAMPLE_W = 24, L = 24'h123456, R = 24'hABCDEF held valid -> decoded slots 4..27 match the samples, validity = 0, even parity holds in every subframe.
REQ-032 SAMPLE_W = 16, L = 16'h8001 -> slots 4..11 = 0, slot 12 = 1, slot 27 = 1, parity slot = 0.
REQ-033 sample_valid_i held low -> underrun_o pulses once per frame, audio = 0, validity = 1 in both subframes, preambles still valid BMC.
REQ-034 Run 2 blocks -> block_start_o pulses every 384 loads, Z only at count 0. With SPDIF_TX_CHSTAT_EN and cs_i = 24'h000004, the channel-status bit = 1 only in frame 2. Reset asserted at half-bit 30 -> spdif_o = 0 at once, and the next subframe is Z.
